arb_req_ctrl: RTL and testbench

Request-side front end for the 4-client fixed-priority arbiter: sits directly upstream of it, driving req1..req4 and consuming gnt1..gnt4. Each client posts request tokens on a valid/ready port. The block queues the tokens as a per-client pending count and holds the matching reqN high until a grant arrives. It reports grant completion, timeouts and protocol violations (grant overrun, spurious grant, multiple grants) back to the clients.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/arb_req_chan.sv | 126 ++++++++++++
 rtl/arb_req_ctrl.sv | 78 +++++++
 tb/tb_arb_req_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter request front end.
// Also imported by the bench so it sees the same TIMEOUT/MAX_GNT/PEND_W.
package arb_pkg;

    localparam int unsigned NUM_CLIENTS = 4;
    localparam int unsigned TIMEOUT     = 32;
    localparam int unsigned MAX_GNT     = 3;
    localparam int unsigned PEND_W      = 3;
    localparam int unsigned CNT_W       = $clog2(NUM_CLIENTS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGnt,
        StDrain
    } chan_state_e;

    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_CLIENTS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One client channel: pending-token counter, request/grant FSM,
// wait (timeout) and hold (overrun) counters.
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int unsigned Timeout = TIMEOUT,
    parameter int unsigned MaxGnt  = MAX_GNT,
    parameter int unsigned PendW   = PEND_W
) (
    input  logic clock,
    input  logic rst,
    input  logic valid_i,
    output logic ready_o,
    input  logic gnt_i,
    output logic req_o,
    output logic done_o,
    output logic err_o,
    output logic idle_o
);

    localparam int unsigned WaitW = $clog2(Timeout + 1);
    localparam int unsigned HoldW = $clog2(MaxGnt + 1);

    localparam logic [PendW-1:0] PendMax   = {PendW{1'b1}};
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(Timeout - 1);
    localparam logic [HoldW-1:0] HoldLimit = HoldW'(MaxGnt);

    chan_state_e      state_q, state_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             inc, dec;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
            wait_q  <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q != '0) begin
                    state_d = StReq;
                    wait_d  = '0;
                end
            end
            StReq: begin
                if (gnt_i) begin
                    state_d = StGnt;
                    wait_d  = '0;
                    hold_d  = HoldW'(1);
                end else if (wait_q == WaitLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    dec     = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StGnt: begin
                if (!gnt_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    dec     = 1'b1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                    // Overrun: the token is retired now, DRAIN just waits out the grant.
                    if (hold_d == HoldLimit) begin
                        state_d = StDrain;
                        err_d   = 1'b1;
                        dec     = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!gnt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        inc    = valid_i && (pend_q != PendMax);
        pend_d = pend_q;
        if (inc && !dec) begin
            pend_d = pend_q + PendW'(1);
        end else if (dec && !inc) begin
            pend_d = pend_q - PendW'(1);
        end
        req_d = (state_d == StReq);
    end

    always_comb begin
        ready_o = (pend_q != PendMax);
        idle_o  = (state_q == StIdle);
        req_o   = req_q;
        done_o  = done_q;
        err_o   = err_q;
    end

endmodule

// File: rtl/arb_req_ctrl.sv
// Request-side front end for the 4-client fixed-priority arbiter:
// four independent channels plus the sticky grant-protocol error flags.
module arb_req_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned Timeout = TIMEOUT,
    parameter int unsigned MaxGnt  = MAX_GNT,
    parameter int unsigned PendW   = PEND_W
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] cli_valid_i,
    output logic [NUM_CLIENTS-1:0] cli_ready_o,
    output logic [NUM_CLIENTS-1:0] cli_done_o,
    output logic [NUM_CLIENTS-1:0] cli_err_o,
    output logic                   req1_o,
    output logic                   req2_o,
    output logic                   req3_o,
    output logic                   req4_o,
    input  logic                   gnt1_i,
    input  logic                   gnt2_i,
    input  logic                   gnt3_i,
    input  logic                   gnt4_i,
    output logic                   err_multi_o,
    output logic                   err_spur_o
);

    logic [NUM_CLIENTS-1:0] gnt;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] idle;
    logic                   err_multi_q, err_multi_d;
    logic                   err_spur_q, err_spur_d;

    assign gnt = {gnt4_i, gnt3_i, gnt2_i, gnt1_i};

    for (genvar i = 0; i < int'(NUM_CLIENTS); i++) begin : gen_chan
        arb_req_chan #(
            .Timeout (Timeout),
            .MaxGnt  (MaxGnt),
            .PendW   (PendW)
        ) u_chan (
            .clock   (clock),
            .rst     (rst),
            .valid_i (cli_valid_i[i]),
            .ready_o (cli_ready_o[i]),
            .gnt_i   (gnt[i]),
            .req_o   (req[i]),
            .done_o  (cli_done_o[i]),
            .err_o   (cli_err_o[i]),
            .idle_o  (idle[i])
        );
    end

    assign req1_o = req[0];
    assign req2_o = req[1];
    assign req3_o = req[2];
    assign req4_o = req[3];

    always_comb begin
        err_multi_d = err_multi_q | (count_ones(gnt) > CNT_W'(1));
        err_spur_d  = err_spur_q | (|(gnt & idle));
    end

    // Sticky until reset; the clients decide what to do about a misbehaving arbiter.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_multi_q <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            err_multi_q <= err_multi_d;
            err_spur_q  <= err_spur_d;
        end
    end

    assign err_multi_o = err_multi_q;
    assign err_spur_o  = err_spur_q;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a timestamp-based reference model of the channel rules.
module tb_arb_req_ctrl;
    import arb_pkg::*;

    localparam int Cap = (1 << PEND_W) - 1;
    localparam int PIdle = 0, PReq = 1, PGnt = 2, PDrain = 3;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] cli_valid = '0;
    logic [3:0] cli_ready, cli_done, cli_err;
    logic       req1, req2, req3, req4;
    logic       gnt1 = 1'b0, gnt2 = 1'b0, gnt3 = 1'b0, gnt4 = 1'b0;
    logic       err_multi, err_spur;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         pend[4], phase[4], t_req[4], t_gnt[4];
    int         cyc;
    logic [3:0] e_ready, e_done, e_err, e_req;
    logic       e_multi, e_spur;

    // Bench-side arbiter state
    int arb_wait, arb_hold, arb_tgt;

    always #5 clock = ~clock;

    arb_req_ctrl dut (
        .clock       (clock),
        .rst         (rst),
        .cli_valid_i (cli_valid),
        .cli_ready_o (cli_ready),
        .cli_done_o  (cli_done),
        .cli_err_o   (cli_err),
        .req1_o      (req1),
        .req2_o      (req2),
        .req3_o      (req3),
        .req4_o      (req4),
        .gnt1_i      (gnt1),
        .gnt2_i      (gnt2),
        .gnt3_i      (gnt3),
        .gnt4_i      (gnt4),
        .err_multi_o (err_multi),
        .err_spur_o  (err_spur)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            pend[c] = 0; phase[c] = PIdle; t_req[c] = 0; t_gnt[c] = 0;
        end
        cyc = 0;
        e_ready = 4'b1111; e_done = '0; e_err = '0; e_req = '0;
        e_multi = 1'b0; e_spur = 1'b0;
        arb_wait = -1; arb_hold = 0; arb_tgt = 0;
    endtask

    // Advance the model by one clock using the inputs applied during cycle cyc.
    task automatic model_step(input logic [3:0] v, input logic [3:0] g);
        int dec;
        e_done = '0;
        e_err  = '0;
        if ($countones(g) > 1) e_multi = 1'b1;
        for (int c = 0; c < 4; c++) begin
            dec = 0;
            case (phase[c])
                PIdle: begin
                    if (g[c]) e_spur = 1'b1;
                    if (pend[c] > 0) begin
                        phase[c] = PReq;
                        t_req[c] = cyc + 1;
                    end
                end
                PReq: begin
                    if (g[c]) begin
                        phase[c] = PGnt;
                        t_gnt[c] = cyc;
                    end else if (cyc - t_req[c] + 1 == int'(TIMEOUT)) begin
                        e_err[c] = 1'b1; dec = 1; phase[c] = PIdle;
                    end
                end
                PGnt: begin
                    if (!g[c]) begin
                        e_done[c] = 1'b1; dec = 1; phase[c] = PIdle;
                    end else if (cyc - t_gnt[c] + 1 == int'(MAX_GNT)) begin
                        e_err[c] = 1'b1; dec = 1; phase[c] = PDrain;
                    end
                end
                default: if (!g[c]) phase[c] = PIdle;
            endcase
            pend[c] = pend[c] + ((v[c] && pend[c] != Cap) ? 1 : 0) - dec;
            e_ready[c] = (pend[c] != Cap);
            e_req[c]   = (phase[c] == PReq);
        end
        cyc++;
    endtask

    task automatic compare_all(input string pfx);
        chk({pfx, ".ready"}, 32'(cli_ready), 32'(e_ready));
        chk({pfx, ".done"},  32'(cli_done),  32'(e_done));
        chk({pfx, ".err"},   32'(cli_err),   32'(e_err));
        chk({pfx, ".req"},   32'({req4, req3, req2, req1}), 32'(e_req));
        chk({pfx, ".multi"}, 32'(err_multi), 32'(e_multi));
        chk({pfx, ".spur"},  32'(err_spur),  32'(e_spur));
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs sampled likewise.
    task automatic tick(input string pfx, input logic [3:0] v, input logic [3:0] g);
        cli_valid = v;
        {gnt4, gnt3, gnt2, gnt1} = g;
        @(posedge clock);
        model_step(v, g);
        #1;
        compare_all(pfx);
    endtask

    // Fixed-priority arbiter stand-in: short random latency, random hold length.
    task automatic arb_gnt(input int wmax, input int hmax, output logic [3:0] g);
        logic [3:0] r;
        logic       found;
        r = {req4, req3, req2, req1};
        g = '0;
        if (arb_hold == 0 && r != 0) begin
            if (arb_wait < 0) arb_wait = int'($urandom_range(wmax, 0));
            if (arb_wait == 0) begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (r[i] && !found) begin
                        found = 1'b1; arb_tgt = i;
                    end
                end
                arb_hold = int'($urandom_range(hmax, 1));
                arb_wait = -1;
            end else begin
                arb_wait--;
            end
        end
        if (arb_hold > 0) begin
            g[arb_tgt] = 1'b1;
            arb_hold--;
        end
    endtask

    task automatic do_reset(input string pfx);
        rst = 1'b1;
        cli_valid = '0;
        {gnt4, gnt3, gnt2, gnt1} = '0;
        #1;
        model_reset();
        compare_all(pfx);
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        int         n;
        int         done_cnt;
        int         err_cnt;
        logic       seen;

        // Reset, single token on client 1, 2-cycle grant
        do_reset("rst0");
        for (int i = 0; i < 10; i++) tick("s1.idle", '0, '0);
        tick("s1.valid", 4'b0001, '0);
        tick("s1.wait", '0, '0);
        chk("s1.req1_at_T+2", 32'(req1), 32'd1);
        tick("s1.gnt", '0, 4'b0001);
        chk("s1.req1_low_after_gnt", 32'(req1), 32'd0);
        tick("s1.gnt", '0, 4'b0001);
        tick("s1.gntlow", '0, '0);
        chk("s1.done_pulse", 32'(cli_done), 32'd1);
        for (int i = 0; i < 4; i++) tick("s1.after", '0, '0);

        // Eight tokens on client 3, grant never arrives
        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            tick("s2.post", 4'b0100, '0);
            if (i == 6) chk("s2.ready_full", 32'(cli_ready[2]), 32'd0);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick("s2.wait", '0, '0);
            if (cli_err[2]) n++;
        end
        chk("s2.timeout_count", 32'(n), 32'd1);
        chk("s2.ready_after_timeout", 32'(cli_ready[2]), 32'd1);

        // Grant overrun on client 2
        do_reset("rst3");
        tick("s3.post", 4'b0010, '0);
        tick("s3.wait", '0, '0);
        for (int i = 0; i < 5; i++) tick("s3.gnt", '0, 4'b0010);
        for (int i = 0; i < 4; i++) tick("s3.after", '0, '0);

        // Two grants in one cycle, then sticky
        do_reset("rst4");
        tick("s4.multi", '0, 4'b1001);
        for (int i = 0; i < 5; i++) tick("s4.hold", '0, '0);
        chk("s4.multi_sticky", 32'(err_multi), 32'd1);

        // Spurious grant on idle client 3
        do_reset("rst5");
        tick("s5.spur", '0, 4'b0100);
        for (int i = 0; i < 3; i++) tick("s5.hold", '0, '0);

        // All four clients post two tokens each against the bench arbiter
        do_reset("rst6");
        tick("s6.post", 4'b1111, '0);
        tick("s6.post", 4'b1111, '0);
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 200 && done_cnt < 8; i++) begin
            arb_gnt(1, 2, g);
            tick("s6.run", '0, g);
            done_cnt += $countones(cli_done);
            err_cnt  += $countones(cli_err);
        end
        chk("s6.done_total", 32'(done_cnt), 32'd8);
        chk("s6.err_total", 32'(err_cnt), 32'd0);

        // Reset in the middle of a grant
        tick("s7.post", 4'b1111, '0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            arb_gnt(1, 2, g);
            tick("s7.run", '0, g);
            if (g != 0) seen = 1'b1;
        end
        chk("s7.grant_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("s7.rst_req", 32'({req4, req3, req2, req1}), 32'd0);
        chk("s7.rst_ready", 32'(cli_ready), 32'hF);
        chk("s7.rst_done_err", 32'({cli_done, cli_err}), 32'd0);
        do_reset("rst7");

        // Random traffic with a looser arbiter: timeouts, overruns, stray grants
        for (int i = 0; i < 600; i++) begin
            arb_gnt(3, 4, g);
            if ($urandom_range(39, 0) == 0) g = g | 4'(1 << $urandom_range(3, 0));
            tick("rnd", 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0)), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
